// File: rtl/vga_host_pkg.sv
// Shared definitions for the VGA host bridge: register map, screen sizes,
// queue entry layout and bridge FSM states.
package vga_host_pkg;

    localparam logic [2:0] REG_STATUS  = 3'd0;
    localparam logic [2:0] REG_DATA    = 3'd1;
    localparam logic [2:0] REG_CUR_LO  = 3'd2;
    localparam logic [2:0] REG_CUR_HI  = 3'd3;
    localparam logic [2:0] REG_CONTROL = 3'd4;
    localparam logic [2:0] REG_COLOR   = 3'd5;

    localparam int unsigned CELLS_80X25 = 2000;
    localparam int unsigned CELLS_64X30 = 1920;

    localparam int unsigned ENTRY_W = 12;

    typedef struct packed {
        logic       wr;
        logic [2:0] rg;
        logic [7:0] data;
    } entry_t;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ISSUE,
        ST_HOLD,
        ST_WAIT
    } state_t;

endpackage

// File: rtl/vga_host_fifo.sv
// First-word-fall-through request queue for the VGA host bridge.
// DEPTH must be a power of two so the pointers wrap naturally.
module vga_host_fifo
    import vga_host_pkg::*;
#(
    parameter int unsigned DEPTH = 8
) (
    input  logic                     clk_i,
    input  logic                     rst_ni,
    input  logic                     push_i,
    input  entry_t                   wdata_i,
    input  logic                     pop_i,
    output entry_t                   rdata_o,
    output logic                     full_o,
    output logic                     empty_o,
    output logic [$clog2(DEPTH):0]   count_o
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

    entry_t        mem_q [DEPTH];
    logic [AW-1:0] wr_ptr_q, rd_ptr_q;
    logic [AW:0]   count_q;
    logic          do_push, do_pop;

    assign full_o  = (count_q == FULL_CNT);
    assign empty_o = (count_q == '0);
    assign count_o = count_q;
    assign rdata_o = mem_q[rd_ptr_q];
    assign do_push = push_i && !full_o;
    assign do_pop  = pop_i && !empty_o;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (do_push) wr_ptr_q <= wr_ptr_q + AW'(1);
            if (do_pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
            case ({do_push, do_pop})
                2'b10:   count_q <= count_q + (AW+1)'(1);
                2'b01:   count_q <= count_q - (AW+1)'(1);
                default: count_q <= count_q;
            endcase
        end
    end

    always_ff @(posedge clk_i) begin
        if (do_push) mem_q[wr_ptr_q] <= wdata_i;
    end

endmodule

// File: rtl/vga_host_bridge.sv
// Host front end for the text-mode VGA register engine: queues host accesses,
// replays them on the engine command port and tracks a shadow cursor.
// Optional read path enabled by defining VGA_HOST_READ_EN.
module vga_host_bridge
    import vga_host_pkg::*;
#(
    parameter int unsigned FIFO_DEPTH = 8,
    parameter int unsigned CELLS      = CELLS_80X25
) (
    input  logic        i_clk,
    input  logic        i_rst_n,
    input  logic        i_host_valid,
    output logic        o_host_ready,
    input  logic        i_host_wr,
    input  logic [2:0]  i_host_reg,
    input  logic [7:0]  i_host_wdata,
    output logic        o_host_rvalid,
    output logic [7:0]  o_host_rdata,
    output logic [7:0]  o_cmd,
    output logic [10:0] o_cur_adr,
    output logic [7:0]  o_port,
    output logic        o_cs_h,
    output logic        o_rl_wh,
    input  logic        i_ready_h,
    input  logic [7:0]  i_port
);

`ifdef VGA_HOST_READ_EN
    localparam bit READ_EN = 1'b1;
`else
    localparam bit READ_EN = 1'b0;
`endif

    localparam int unsigned CNT_W    = $clog2(FIFO_DEPTH) + 1;
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(FIFO_DEPTH);
    localparam logic [10:0] CELLS_ADR = 11'(CELLS);

    entry_t             host_entry, head;
    logic               fifo_push, fifo_pop, fifo_full, fifo_empty;
    logic [CNT_W-1:0]   fifo_count;

    state_t      state_q, state_d;
    logic [7:0]  cmd_q, cmd_d, port_q, port_d, rdata_q, rdata_d;
    logic [10:0] cur_q, cur_d, cur_inc;
    logic        rlwh_q, rlwh_d, rvalid_q, rvalid_d, cs_h;

    assign host_entry = '{wr: i_host_wr, rg: i_host_reg, data: i_host_wdata};
    // Reads complete the host handshake even when they are not queued.
    assign fifo_push  = i_host_valid && !fifo_full && (i_host_wr || READ_EN);
    assign cur_inc    = cur_q + 11'd1;

    vga_host_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
        .clk_i   (i_clk),
        .rst_ni  (i_rst_n),
        .push_i  (fifo_push),
        .wdata_i (host_entry),
        .pop_i   (fifo_pop),
        .rdata_o (head),
        .full_o  (fifo_full),
        .empty_o (fifo_empty),
        .count_o (fifo_count)
    );

    always_comb begin
        state_d  = state_q;
        cmd_d    = cmd_q;
        port_d   = port_q;
        rlwh_d   = rlwh_q;
        cur_d    = cur_q;
        rdata_d  = rdata_q;
        rvalid_d = 1'b0;
        fifo_pop = 1'b0;
        cs_h     = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (!fifo_empty && i_ready_h) begin
                    fifo_pop = 1'b1;
                    cmd_d    = {5'b0, head.rg};
                    port_d   = head.data;
                    rlwh_d   = head.wr;
                    if (head.wr && head.rg == REG_CUR_LO) cur_d[7:0]  = head.data;
                    if (head.wr && head.rg == REG_CUR_HI) cur_d[10:8] = head.data[2:0];
                    state_d  = ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                cs_h    = 1'b1;
                state_d = ST_HOLD;
            end
            ST_HOLD: state_d = ST_WAIT;
            ST_WAIT: begin
                if (i_ready_h) begin
                    if (!rlwh_q) begin
                        rdata_d  = READ_EN ? i_port : '0;
                        rvalid_d = READ_EN;
                    end else if (cmd_q[2:0] == REG_DATA) begin
                        cur_d = (cur_inc == CELLS_ADR) ? '0 : cur_inc;
                    end
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q  <= ST_IDLE;
            cmd_q    <= '0;
            port_q   <= '0;
            rlwh_q   <= 1'b0;
            cur_q    <= '0;
            rdata_q  <= '0;
            rvalid_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            cmd_q    <= cmd_d;
            port_q   <= port_d;
            rlwh_q   <= rlwh_d;
            cur_q    <= cur_d;
            rdata_q  <= rdata_d;
            rvalid_q <= rvalid_d;
        end
    end

    assign o_host_ready  = !fifo_full;
    assign o_host_rvalid = rvalid_q;
    assign o_host_rdata  = rdata_q;
    assign o_cmd         = cmd_q;
    assign o_port        = port_q;
    assign o_rl_wh       = rlwh_q;
    assign o_cur_adr     = cur_q;
    assign o_cs_h        = cs_h;

    a_full_count : assert property (@(posedge i_clk) disable iff (!i_rst_n)
        fifo_full == (fifo_count == FULL_CNT));

endmodule

// File: doc/vga_host_bridge.md
# vga_host_bridge

Host-side front end for the text-mode VGA register engine. Accepts host register accesses over a valid/ready byte interface, buffers them in a small in-order queue, and replays each one into the engine's single-shot command port (cmd / cs / read-write / data / ready), waiting for the engine's ready handshake. Keeps a shadow 11-bit cursor address that matches the engine's post-write auto-increment, and returns read data to the host.

## Interface
- FIFO_DEPTH, 8: queue entries; power of two, 2..32
- CELLS, 2000: screen cells (80x25 = 2000, 64x30 = 1920); cursor wrap point
- i_clk  in  1  clock
- i_rst_n  in  1  reset; one clock; reset is asynchronous and active-low
- i_host_valid  in  1  host request valid
- o_host_ready  out  1  queue can accept (= !full)
- i_host_wr  in  1  1 = write, 0 = read
- i_host_reg  in  3  register: 0 status, 1 data, 2 cur lo, 3 cur hi, 4 control, 5 color
- i_host_wdata  in  8  write data
- o_host_rvalid  out  1  one-cycle read-return pulse
- o_host_rdata  out  8  read data, valid with o_host_rvalid
- o_cmd  out  8  engine command ({5'b0, reg})
- o_cur_adr  out  11  shadow cursor address
- o_port  out  8  engine write data
- o_cs_h  out  1  engine chip select, one-cycle pulse
- o_rl_wh  out  1  engine direction (0 read, 1 write)
- i_ready_h  in  1  engine ready
- i_port  in  8  engine read data

## Operation
- Queue entry {wr, reg[2:0], data[7:0]} = 12 bits; pushed on i_host_valid && o_host_ready; strictly in order.
- Reg values 6/7 are queued and issued unchanged; the engine answers reads with 0xEE.
- Push and pop in the same cycle are legal at any non-full level. Push is refused when full. Pop happens only on the IDLE->ISSUE transition.
- FSM:
  - IDLE: if queue non-empty && i_ready_h, pop the head into the o_cmd/o_port/o_rl_wh registers, then go to ISSUE.
  - ISSUE: o_cs_h = 1; go to HOLD.
  - HOLD: o_cs_h = 0; o_cmd/o_port/o_rl_wh held; i_ready_h ignored; go to WAIT.
  - WAIT: when i_ready_h = 1, for a read capture i_port into o_host_rdata and pulse o_host_rvalid; go to IDLE.
- o_cmd/o_port/o_rl_wh stay stable from ISSUE until the next pop.
- Shadow cursor updates at pop time, before ISSUE, so o_cur_adr is already updated during ISSUE and HOLD:
  - write reg 2: [7:0] <= data
  - write reg 3: [10:8] <= data[2:0]; data[7:3] ignored
- Data-write increment: in WAIT on i_ready_h = 1, for a write to reg 1, shadow <= shadow + 1. If the result equals CELLS, shadow <= 0. This mirrors the engine.
- Reads never modify the shadow.

## Timing
- Reset values:
  - o_host_ready = 1 (queue empty)
  - o_host_rvalid = 0, o_host_rdata = 0x00
  - o_cmd = 0, o_cur_adr = 0, o_port = 0
  - o_cs_h = 0, o_rl_wh = 0
  - FSM = IDLE, queue empty
- Reset mid-transaction aborts it: cs drops asynchronously and queued entries are lost. The engine has no reset, so the bridge issues nothing until i_ready_h = 1.
- The minimum engine transaction is 4 bridge cycles (IDLE, ISSUE, HOLD, WAIT). The engine's own latency stretches WAIT.
- Latency:
  - Host push into an empty queue with i_ready_h = 1: o_cs_h rises 2 cycles later (push edge, then IDLE pop edge).
  - Read data: o_host_rvalid is asserted the cycle after WAIT sees ready.
- o_host_ready drops the cycle after the push that fills the queue.

## Configuration
- VGA_HOST_READ_EN defined: reads are queued, issued with o_rl_wh = 0, and returned on o_host_rvalid/o_host_rdata.
- Undefined: reads are accepted (handshake completes) but not queued. o_host_rvalid and o_host_rdata are tied 0. Write behaviour is identical in both builds.

## Structure
- Shared package vga_host_pkg holds:
  - register address constants (REG_STATUS..REG_COLOR)
  - CELLS values for each resolution
  - the queue entry width/typedef
- One sub-module, vga_host_fifo: synchronous, first-word-fall-through, depth FIFO_DEPTH, with full/empty flags and count. The FSM and shadow cursor live in the top.

## Test plan
- Write reg 2 = 0x34, then reg 3 = 0x05 -> two cs pulses; o_cur_adr = 0x534 during the second pulse; o_rl_wh = 1 and o_cmd = 3 held through HOLD.
- Cursor 1999 (CELLS 2000), write reg 1 = 0x41 -> o_port = 0x41 with cs; o_cur_adr = 0 after the engine returns ready.
- Read reg 4 with engine model returning 0x01 (READ_EN) -> o_host_rvalid pulses once with o_host_rdata = 0x01; without READ_EN -> no cs, no rvalid.
- Push 9 writes back-to-back with the engine held not-ready (FIFO_DEPTH 8) -> o_host_ready = 0 after the 8th push; release ready -> 8 cs pulses in order, each at least 4 cycles apart.
- Assert i_rst_n low during HOLD with 3 entries queued -> all outputs at reset values immediately; no further cs after release until new pushes arrive.
- Engine ready held low for 10 cycles after cs -> bridge stays in WAIT; cs is not re-asserted; the next entry is issued only after ready returns.
